calc_display_sequencer: RTL

- Control FSM between the calculator input buttons/switches and the VGA text renderer.
- Holds working operands A and B, sequences the arithmetic (single-cycle add/sub, iterative 16-step multiply/divide), and produces result C plus an error/overflow flag.
- Publishes A/B/C/flag to the renderer through shadow registers that update only at a frame boundary, so the display never tears mid-frame.

---
 rtl/calc_display_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/calc_display_sequencer.sv
// Calculator control FSM: operand entry, add/sub/mul/div sequencing and display publishing.
// Optional macro TEAR_FREE_EN: publish A/B/C/flag through frame-boundary shadow registers.
module calc_display_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [9:0]  VBLANK_LINE = 10'd516
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load_a,
  input  logic             btn_load_b,
  input  logic             btn_exec,
  input  logic             btn_clear,
  input  logic [1:0]       op,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  output logic [WIDTH-1:0] A_disp,
  output logic [WIDTH-1:0] B_disp,
  output logic [WIDTH-1:0] C_disp,
  output logic             flag_disp,
  output logic             busy
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, ARITH, ITER, WB} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_r, b_r, c_r;
  logic             flag_r;

  // Iteration datapath: opa = dividend/quotient, opb = multiplier/divisor
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opa, opb;
  logic [W2-1:0]    acc, mcand;
  logic [CNT_W-1:0] cnt;

  logic             ld_a_en, ld_b_en, start_en, res_wr;
  logic [WIDTH-1:0] res_c;
  logic             res_f;
  logic [WIDTH-1:0] opa_n, opb_n;
  logic [W2-1:0]    acc_n, mcand_n;
  logic [WIDTH:0]   sum, rem_sh, rem_sub;

  // Next-state, control enables and iteration step
  always_comb begin
    state_next = state;
    ld_a_en    = 1'b0;
    ld_b_en    = 1'b0;
    start_en   = 1'b0;
    res_wr     = 1'b0;
    res_c      = '0;
    res_f      = 1'b0;
    acc_n      = acc;
    mcand_n    = mcand;
    opa_n      = opa;
    opb_n      = opb;
    sum        = {1'b0, opa} + {1'b0, opb};
    rem_sh     = {acc[WIDTH-1:0], opa[WIDTH-1]};
    rem_sub    = rem_sh - {1'b0, opb};

    case (state)
      IDLE: begin
        if (btn_load_a || btn_load_b) begin
          ld_a_en = btn_load_a;
          ld_b_en = btn_load_b;
        end else if (btn_exec) begin
          start_en   = 1'b1;
          state_next = (op == OP_MUL || (op == OP_DIV && b_r != '0)) ? ITER : ARITH;
        end
      end
      ARITH: begin
        res_wr     = 1'b1;
        state_next = IDLE;
        case (op_q)
          OP_ADD: begin
            res_c = sum[WIDTH-1:0];
            res_f = sum[WIDTH];
          end
          OP_SUB: begin
            res_c = opa - opb;
            res_f = (opa < opb);
          end
          default: begin
            // Only a divide by zero reaches ARITH with a non add/sub op
            res_c = '1;
            res_f = 1'b1;
          end
        endcase
      end
      ITER: begin
        if (op_q == OP_MUL) begin
          if (opb[0]) acc_n = acc + mcand;
          mcand_n = mcand << 1;
          opb_n   = opb >> 1;
        end else if (rem_sh >= {1'b0, opb}) begin
          acc_n = W2'(rem_sub[WIDTH-1:0]);
          opa_n = {opa[WIDTH-2:0], 1'b1};
        end else begin
          acc_n = W2'(rem_sh);
          opa_n = {opa[WIDTH-2:0], 1'b0};
        end
        if (cnt == CNT_LAST) state_next = WB;
      end
      WB: begin
        res_wr     = 1'b1;
        state_next = IDLE;
        if (op_q == OP_MUL) begin
          res_c = acc[WIDTH-1:0];
          res_f = |acc[W2-1:WIDTH];
        end else begin
          res_c = opa;
          res_f = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (btn_clear) begin
      state_next = IDLE;
      ld_a_en    = 1'b0;
      ld_b_en    = 1'b0;
      start_en   = 1'b0;
      res_wr     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Working registers and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= '0;
      flag_r <= 1'b0;
      op_q   <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else begin
      if (btn_clear) begin
        a_r    <= '0;
        b_r    <= '0;
        c_r    <= '0;
        flag_r <= 1'b0;
      end else begin
        if (ld_a_en) a_r <= sw;
        if (ld_b_en) b_r <= sw;
        if (res_wr) begin
          c_r    <= res_c;
          flag_r <= res_f;
        end
      end

      if (start_en) begin
        op_q  <= op;
        opa   <= a_r;
        opb   <= b_r;
        acc   <= '0;
        mcand <= W2'(a_r);
        cnt   <= '0;
      end else if (btn_clear) begin
        cnt <= '0;
      end else if (state == ITER) begin
        acc   <= acc_n;
        mcand <= mcand_n;
        opa   <= opa_n;
        opb   <= opb_n;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef TEAR_FREE_EN
  logic dirty;
  logic tick;
  logic wr_any;

  assign tick   = (vCount == VBLANK_LINE) && (hCount == 10'd0);
  assign wr_any = btn_clear || ld_a_en || ld_b_en || res_wr;

  // A write on the tick edge keeps dirty set so it is published next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      A_disp    <= '0;
      B_disp    <= '0;
      C_disp    <= '0;
      flag_disp <= 1'b0;
      dirty     <= 1'b0;
    end else begin
      if (tick && dirty) begin
        A_disp    <= a_r;
        B_disp    <= b_r;
        C_disp    <= c_r;
        flag_disp <= flag_r;
      end
      if (wr_any)    dirty <= 1'b1;
      else if (tick) dirty <= 1'b0;
    end
  end
`else
  logic unused_timing;

  assign unused_timing = ^{hCount, vCount, VBLANK_LINE};
  assign A_disp        = a_r;
  assign B_disp        = b_r;
  assign C_disp        = c_r;
  assign flag_disp     = flag_r;
`endif

endmodule
